// File: rtl/flop_mode_cfg_if.sv
// Host-side handshake for the flop mode configuration sequencer: load request
// plus a valid/ready stream of 3-bit mode codes.
interface flop_mode_cfg_if;
    logic       start;
    logic       mode_valid;
    logic       mode_ready;
    logic [2:0] mode_data;

    modport master (output start, output mode_valid, output mode_data, input mode_ready);
    modport slave  (input start, input mode_valid, input mode_data, output mode_ready);
endinterface

// File: rtl/flop_mode_cfg_ctrl.sv
// Collects one mode code per flop site, shifts them into the serial mode chain,
// verifies the chain by recirculating readback and strobes the latch only on a clean compare.
module flop_mode_cfg_ctrl #(
    parameter int NUM_CELLS = 16,
    parameter int IDX_W     = $clog2(NUM_CELLS)
) (
    input  logic             clk,
    input  logic             rst,
    flop_mode_cfg_if.slave   host,
    output logic             cfg_sdo,
    output logic             cfg_shift,
    input  logic             cfg_sdi,
    output logic             cfg_latch,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] err_cell
);
    localparam int CHAIN_W = 3 * NUM_CELLS;
    localparam int BIT_W   = $clog2(CHAIN_W);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_VERIFY  = 3'd3,
        ST_LATCH   = 3'd4,
        ST_FAIL    = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [IDX_W-1:0]   word_cnt_r;
    logic [BIT_W-1:0]   bit_cnt_r;
    logic [CHAIN_W-1:0] buf_r;
    logic               error_r;
    logic [IDX_W-1:0]   err_cell_r;

    logic               xfer_s;
    logic               last_word_s;
    logic               last_bit_s;
    logic               mismatch_s;
    logic [IDX_W-1:0]   cell_idx_s;
    logic               ready_s;
    logic               shift_s;
    logic               sdo_s;
    logic               latch_s;
    logic               busy_s;
    logic               done_s;

    assign xfer_s      = host.mode_valid && (state_r == ST_COLLECT);
    assign last_word_s = (word_cnt_r == IDX_W'(NUM_CELLS - 1));
    assign last_bit_s  = (bit_cnt_r == BIT_W'(CHAIN_W - 1));
    assign mismatch_s  = (state_r == ST_VERIFY) && (cfg_sdi != buf_r[CHAIN_W-1]);
    // Bits stream cell N-1 first, three per cell, so the bit count maps back to a cell index.
    assign cell_idx_s  = IDX_W'(NUM_CELLS - 1) - IDX_W'(bit_cnt_r / BIT_W'(3));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (host.start) state_s = ST_COLLECT;
                else            state_s = ST_IDLE;
            end
            ST_COLLECT: begin
                if (xfer_s && last_word_s) state_s = ST_SHIFT;
                else                       state_s = ST_COLLECT;
            end
            ST_SHIFT: begin
                if (last_bit_s) state_s = ST_VERIFY;
                else            state_s = ST_SHIFT;
            end
            ST_VERIFY: begin
                if (!last_bit_s)                 state_s = ST_VERIFY;
                else if (error_r || mismatch_s)  state_s = ST_FAIL;
                else                             state_s = ST_LATCH;
            end
            ST_LATCH: state_s = ST_DONE;
            ST_FAIL:  state_s = ST_DONE;
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Output decode; in VERIFY the tail is fed straight back so the chain ends restored.
    always_comb begin
        ready_s = 1'b0;
        shift_s = 1'b0;
        sdo_s   = 1'b0;
        latch_s = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_COLLECT: begin
                ready_s = 1'b1;
                busy_s  = 1'b1;
            end
            ST_SHIFT: begin
                shift_s = 1'b1;
                sdo_s   = buf_r[CHAIN_W-1];
                busy_s  = 1'b1;
            end
            ST_VERIFY: begin
                shift_s = 1'b1;
                sdo_s   = cfg_sdi;
                busy_s  = 1'b1;
            end
            ST_LATCH: begin
                latch_s = 1'b1;
                busy_s  = 1'b1;
            end
            ST_FAIL: begin
                busy_s = 1'b1;
            end
            ST_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Datapath: code buffer, word/bit counters and sticky verify result.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_r <= '0;
            bit_cnt_r  <= '0;
            buf_r      <= '0;
            error_r    <= 1'b0;
            err_cell_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (host.start) begin
                        error_r    <= 1'b0;
                        err_cell_r <= '0;
                        word_cnt_r <= '0;
                        bit_cnt_r  <= '0;
                    end
                end
                ST_COLLECT: begin
                    if (xfer_s) begin
                        buf_r      <= {buf_r[CHAIN_W-4:0], host.mode_data};
                        word_cnt_r <= last_word_s ? '0 : word_cnt_r + IDX_W'(1);
                    end
                end
                ST_SHIFT, ST_VERIFY: begin
                    buf_r     <= {buf_r[CHAIN_W-2:0], buf_r[CHAIN_W-1]};
                    bit_cnt_r <= last_bit_s ? '0 : bit_cnt_r + BIT_W'(1);
                    if (mismatch_s && !error_r) begin
                        error_r    <= 1'b1;
                        err_cell_r <= cell_idx_s;
                    end
                end
                default: begin
                    word_cnt_r <= word_cnt_r;
                end
            endcase
        end
    end

    assign host.mode_ready = ready_s;
    assign cfg_shift       = shift_s;
    assign cfg_sdo         = sdo_s;
    assign cfg_latch       = latch_s;
    assign busy            = busy_s;
    assign done            = done_s;
    assign error           = error_r;
    assign err_cell        = err_cell_r;
endmodule

// File: tb/tb_flop_mode_cfg_ctrl.sv
// Directed bench for flop_mode_cfg_ctrl with N=4 and a 12-bit behavioural mode chain.
module tb_flop_mode_cfg_ctrl;
    localparam int N = 4;
    localparam logic [11:0] STUCK_MASK = 12'hF7F;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_sdo, cfg_shift, cfg_sdi, cfg_latch, busy, done, error;
    logic [1:0] err_cell;
    logic [8:0] status;

    always #5 clk = ~clk;

    flop_mode_cfg_if hif();

    flop_mode_cfg_ctrl #(.NUM_CELLS(N), .IDX_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .host      (hif),
        .cfg_sdo   (cfg_sdo),
        .cfg_shift (cfg_shift),
        .cfg_sdi   (cfg_sdi),
        .cfg_latch (cfg_latch),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_cell  (err_cell)
    );

    assign status = {busy, done, error, err_cell, hif.mode_ready, cfg_shift, cfg_sdo, cfg_latch};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Chain model: shifts in at bit 0, tail is bit 11; optional stuck-at-0 on the cell-2 bit1 site once loaded.
    logic [11:0] chain = 12'h000;
    int          sh_cnt = 0;
    bit          stuck_en = 1'b0;
    assign cfg_sdi = chain[11];
    always @(posedge clk) begin
        if (cfg_shift) begin
            chain  <= {chain[10:0], cfg_sdo} & ((stuck_en && sh_cnt >= 11) ? STUCK_MASK : 12'hFFF);
            sh_cnt <= sh_cnt + 1;
        end else begin
            sh_cnt <= 0;
        end
    end

    // Mid-cycle monitors: cumulative event counts and the first 12 bits of each shift burst.
    int busy_tot = 0, latch_tot = 0, ready_tot = 0, xfer_tot = 0, latch_cyc = -1, bc = 0;
    logic [11:0] sdo_vec = 12'h000, sdi_vec = 12'h000;
    always @(negedge clk) begin
        if (busy) busy_tot <= busy_tot + 1;
        if (cfg_latch) begin
            latch_tot <= latch_tot + 1;
            latch_cyc <= cyc;
        end
        if (hif.mode_ready) ready_tot <= ready_tot + 1;
        if (hif.mode_valid && hif.mode_ready) xfer_tot <= xfer_tot + 1;
        if (cfg_shift) begin
            if (bc < 12) begin
                sdo_vec[11-bc] <= cfg_sdo;
                sdi_vec[11-bc] <= cfg_sdi;
            end
            bc <= bc + 1;
        end else begin
            bc <= 0;
        end
    end

    int checks = 0;
    int errs   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One load: r is the cycle offset from the start cycle t.
    task automatic run_load(input logic [11:0] codes, input bit toggle, input int ign_a,
                            input int ign_b, input int rst_at, output int t_done, output int t_latch);
        int t, k, r;
        t_done  = -1;
        t_latch = -1;
        k       = 0;
        hif.start = 1'b1;
        t = cyc;
        step();
        hif.start = 1'b0;
        while (cyc - t < 200) begin
            r = cyc - t;
            if (r == 1) chk("start_clears_error", 32'({error, err_cell}), 32'h0);
            if (r == rst_at) begin
                rst = 1'b1;
                hif.mode_valid = 1'b0;
                step();
                rst = 1'b0;
                chk("rst_outputs_zero", 32'(status), 32'h0);
                return;
            end
            if (done) begin
                t_done  = r;
                t_latch = latch_cyc - t;
                break;
            end
            hif.start = (r == ign_a || r == ign_b);
            if (k < N) begin
                hif.mode_valid = toggle ? r[0] : 1'b1;
                hif.mode_data  = codes[11-3*k -: 3];
            end else begin
                hif.mode_valid = 1'b0;
            end
            if (hif.mode_valid && hif.mode_ready) k++;
            step();
        end
        hif.mode_valid = 1'b0;
        if (t_done >= 0) begin
            hif.start = 1'b1;
            step();
            hif.start = 1'b0;
            chk("start_at_done_ignored", 32'({hif.mode_ready, busy}), 32'h0);
        end else begin
            hif.start = 1'b0;
        end
    endtask

    initial begin
        int td, tl, b0, l0, r0, x0;
        rst = 1'b1;
        hif.start = 1'b0;
        hif.mode_valid = 1'b0;
        hif.mode_data = 3'd0;
        repeat (3) step();
        chk("reset_status", 32'(status), 32'h0);
        rst = 1'b0;
        step();
        chk("idle_status", 32'(status), 32'h0);

        // Codes 7,0,5,2 with no stall.
        b0 = busy_tot; l0 = latch_tot; r0 = ready_tot; x0 = xfer_tot;
        run_load(12'hE2A, 1'b0, -1, -1, -1, td, tl);
        chk("t1_done_cycle", td, 30);
        chk("t1_latch_cycle", tl, 29);
        chk("t1_busy_cycles", busy_tot - b0, 29);
        chk("t1_latch_count", latch_tot - l0, 1);
        chk("t1_ready_cycles", ready_tot - r0, 4);
        chk("t1_xfers", xfer_tot - x0, 4);
        chk("t1_chain", 32'(chain), 32'hE2A);
        chk("t1_sdo_stream", 32'(sdo_vec), 32'hE2A);
        chk("t1_error", 32'(error), 32'h0);

        // Same codes with mode_valid toggling; also a reload over a verified chain.
        b0 = busy_tot; l0 = latch_tot; r0 = ready_tot; x0 = xfer_tot;
        run_load(12'hE2A, 1'b1, -1, -1, -1, td, tl);
        chk("t2_done_cycle", td, 33);
        chk("t2_latch_cycle", tl, 32);
        chk("t2_xfers", xfer_tot - x0, 4);
        chk("t2_ready_cycles", ready_tot - r0, 7);
        chk("t2_latch_count", latch_tot - l0, 1);
        chk("t2_sdi_old_stream", 32'(sdi_vec), 32'hE2A);
        chk("t2_chain", 32'(chain), 32'hE2A);
        chk("t2_error", 32'(error), 32'h0);

        // Start pulses in COLLECT (t+2) and VERIFY (t+20) are ignored.
        l0 = latch_tot; x0 = xfer_tot;
        run_load(12'h5C3, 1'b0, 2, 20, -1, td, tl);
        chk("t3_done_cycle", td, 30);
        chk("t3_xfers", xfer_tot - x0, 4);
        chk("t3_latch_count", latch_tot - l0, 1);
        chk("t3_chain", 32'(chain), 32'h5C3);

        // Stuck-at-0 at cell 2 bit 1.
        stuck_en = 1'b1;
        l0 = latch_tot;
        run_load(12'hFFF, 1'b0, -1, -1, -1, td, tl);
        chk("t4_done_cycle", td, 30);
        chk("t4_error", 32'(error), 32'h1);
        chk("t4_err_cell", 32'(err_cell), 32'h2);
        chk("t4_no_latch", latch_tot - l0, 0);
        repeat (3) step();
        chk("t4_error_sticky", 32'({error, err_cell}), 32'h6);
        stuck_en = 1'b0;

        // Reset during SHIFT at t+6; error cleared by the start itself.
        l0 = latch_tot;
        run_load(12'hE2A, 1'b0, -1, -1, 6, td, tl);
        chk("t5_no_latch", latch_tot - l0, 0);
        step();
        chk("t5_idle_after_rst", 32'(status), 32'h0);

        // Fresh load after the abort.
        l0 = latch_tot;
        run_load(12'h2D4, 1'b0, -1, -1, -1, td, tl);
        chk("t6_done_cycle", td, 30);
        chk("t6_latch_cycle", tl, 29);
        chk("t6_latch_count", latch_tot - l0, 1);
        chk("t6_chain", 32'(chain), 32'h2D4);
        chk("t6_error", 32'(error), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
